// File: rtl/serial_parity_tx.sv
// Serial even-parity transmitter.
// Accepts a parallel word over valid/ready, shifts it out one bit per clock on z,
// then appends a parity bit so each frame carries an even number of 1s.
// Optional feature: define PARITY_ERR_INJ_EN to add the err_inj port, which inverts
// the parity bit of the frame it was accepted with.
module serial_parity_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
`ifdef PARITY_ERR_INJ_EN
  input  logic              err_inj,
`endif
  output logic              din_ready,
  output logic              z,
  output logic              z_valid,
  output logic              frame_end
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StData, StPar} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                acc_q, acc_d;
  logic                z_q, z_d;
  logic                z_valid_q, z_valid_d;
  logic                frame_end_q, frame_end_d;
  logic                parity_bit;
  logic                accept;
`ifdef PARITY_ERR_INJ_EN
  logic                err_q, err_d;
`endif

  // Bit that leaves the word next, depending on transmit order.
  function automatic logic next_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  // Word with the outgoing bit removed.
  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Ready in IDLE and in the parity cycle (back-to-back frames); never during reset.
  always_comb begin
    din_ready = !rst && ((state_q == StIdle) || (state_q == StPar));
  end

  assign accept = din_valid && din_ready;

`ifdef PARITY_ERR_INJ_EN
  assign parity_bit = acc_q ^ err_q;
`else
  assign parity_bit = acc_q;
`endif

  // Next-state: the first data bit is registered on the accept edge itself, so the
  // accumulator starts from that bit rather than from zero.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    z_d         = IDLE_LEVEL;
    z_valid_d   = 1'b0;
    frame_end_d = 1'b0;
`ifdef PARITY_ERR_INJ_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      StIdle, StPar: begin
        if (accept) begin
          state_d   = StData;
          z_d       = next_bit(din);
          z_valid_d = 1'b1;
          acc_d     = next_bit(din);
          shift_d   = shift_word(din);
          cnt_d     = '0;
`ifdef PARITY_ERR_INJ_EN
          err_d     = err_inj;
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        z_valid_d = 1'b1;
        if (cnt_q == LastCnt) begin
          state_d     = StPar;
          z_d         = parity_bit;
          frame_end_d = 1'b1;
          cnt_d       = '0;
        end else begin
          z_d     = next_bit(shift_q);
          acc_d   = acc_q ^ next_bit(shift_q);
          shift_d = shift_word(shift_q);
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      cnt_q       <= '0;
      acc_q       <= 1'b0;
      z_q         <= IDLE_LEVEL;
      z_valid_q   <= 1'b0;
      frame_end_q <= 1'b0;
`ifdef PARITY_ERR_INJ_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      z_q         <= z_d;
      z_valid_q   <= z_valid_d;
      frame_end_q <= frame_end_d;
`ifdef PARITY_ERR_INJ_EN
      err_q       <= err_d;
`endif
    end
  end

  assign z         = z_q;
  assign z_valid   = z_valid_q;
  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_serial_parity_tx.sv
// Scoreboard bench for serial_parity_tx: an LSB-first and an MSB-first instance.
module tb_serial_parity_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din_l, din_m;
  logic       valid_l, valid_m;
  logic       ready_l, ready_m;
  logic       z_l, z_m, zv_l, zv_m, fe_l, fe_m;
`ifdef PARITY_ERR_INJ_EN
  logic       err_inj_l;
`endif

  typedef struct packed {logic z; logic fe;} exp_t;
  exp_t q_l[$];
  exp_t q_m[$];

  int n_tests = 0;
  int n_fail  = 0;
  int run_l = 0, last_run_l = 0;
  int idx_m = 0;
  logic det_m = 1'b0;

  always #5 clk = ~clk;

  serial_parity_tx #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din_l),
    .din_valid (valid_l),
`ifdef PARITY_ERR_INJ_EN
    .err_inj   (err_inj_l),
`endif
    .din_ready (ready_l),
    .z         (z_l),
    .z_valid   (zv_l),
    .frame_end (fe_l)
  );

  serial_parity_tx #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut_msb (
    .clk       (clk),
    .rst       (rst),
    .din       (din_m),
    .din_valid (valid_m),
`ifdef PARITY_ERR_INJ_EN
    .err_inj   (1'b0),
`endif
    .din_ready (ready_m),
    .z         (z_m),
    .z_valid   (zv_m),
    .frame_end (fe_m)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // exp[8] is the first bit on the line, exp[0] the parity bit.
  task automatic push_exp(input bit sel, input logic [8:0] exp);
    exp_t e;
    for (int k = 8; k >= 0; k--) begin
      e.z  = exp[k];
      e.fe = (k == 0);
      if (sel) q_m.push_back(e);
      else     q_l.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge with valid dropped.
  task automatic send(input bit sel, input logic [7:0] d, input logic [8:0] exp);
    bit done = 0;
    if (sel) begin din_m = d; valid_m = 1'b1; end
    else     begin din_l = d; valid_l = 1'b1; end
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (sel ? ready_m : ready_l) begin
        push_exp(sel, exp);
        done = 1;
      end
      @(negedge clk);
    end
    valid_l = 1'b0;
    valid_m = 1'b0;
    check_int("accept_timeout", int'(done), 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      #1;
      if (q_l.size() == 0 && q_m.size() == 0 && !zv_l && !zv_m) done = 1;
    end
    check_int("idle_timeout", int'(done), 1);
  endtask

  // LSB monitor: pops on every valid bit, checks idle line otherwise.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (zv_l) begin
        run_l++;
        if (q_l.size() == 0) begin
          check("lsb_unexpected_bit", zv_l, 1'b0);
        end else begin
          e = q_l.pop_front();
          check("lsb_z", z_l, e.z);
          check("lsb_frame_end", fe_l, e.fe);
        end
      end else begin
        if (run_l != 0) last_run_l = run_l;
        run_l = 0;
        check("lsb_idle_z", z_l, 1'b0);
        check("lsb_idle_frame_end", fe_l, 1'b0);
      end
    end
  end

  // MSB monitor plus a serial parity detector reset at each frame start.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (zv_m) begin
        det_m = (idx_m == 0) ? z_m : (det_m ^ z_m);
        idx_m++;
        if (q_m.size() == 0) begin
          check("msb_unexpected_bit", zv_m, 1'b0);
        end else begin
          e = q_m.pop_front();
          check("msb_z", z_m, e.z);
          check("msb_frame_end", fe_m, e.fe);
        end
        if (fe_m) begin
          check("msb_detector_even", det_m, 1'b0);
          idx_m = 0;
        end
      end else begin
        check("msb_idle_z", z_m, 1'b0);
      end
    end
  end

  initial begin
    int rdy_cnt;
    rst = 1'b1; din_l = '0; din_m = '0; valid_l = 1'b0; valid_m = 1'b0;
`ifdef PARITY_ERR_INJ_EN
    err_inj_l = 1'b0;
`endif
    @(negedge clk);
    valid_l = 1'b1;  // must be ignored while rst is high
    #1;
    check("rst_din_ready", ready_l, 1'b0);
    check("rst_z", z_l, 1'b0);
    check("rst_z_valid", zv_l, 1'b0);
    check("rst_frame_end", fe_l, 1'b0);
    @(negedge clk);
    valid_l = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_ready", ready_l, 1'b1);
    check("post_rst_z_valid", zv_l, 1'b0);
    @(negedge clk);

    // Single frames, LSB first.
    send(0, 8'hA5, 9'b101001010);
    wait_idle();
    check_int("a5_z_valid_run", last_run_l, 9);
    send(0, 8'h07, 9'b111000001);
    wait_idle();
    check_int("07_z_valid_run", last_run_l, 9);
    send(0, 8'h3C, 9'b001111000);
    wait_idle();

    // Back-to-back FF then 01 with valid held.
    din_l = 8'hFF; valid_l = 1'b1; rdy_cnt = 0;
    for (int i = 0; i < 19; i++) begin
      #1;
      if (i == 18) valid_l = 1'b0;
      if (ready_l) rdy_cnt++;
      if (ready_l && valid_l) push_exp(0, (i == 0) ? 9'b111111110 : 9'b100000001);
      if (i == 1) din_l = 8'h01;
      @(negedge clk);
    end
    valid_l = 1'b0;
    wait_idle();
    check_int("b2b_ready_cycles", rdy_cnt, 3);
    check_int("b2b_z_valid_run", last_run_l, 18);

    // Reset during the 4th data bit of FF.
    din_l = 8'hFF; valid_l = 1'b1;
    #1;
    check("mid_rst_ready_idle", ready_l, 1'b1);
    push_exp(0, 9'b111111110);
    @(negedge clk);
    valid_l = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_l.delete();
    #1;
    check("mid_rst_z_valid", zv_l, 1'b0);
    check("mid_rst_z", z_l, 1'b0);
    check("mid_rst_frame_end", fe_l, 1'b0);
    check("mid_rst_ready", ready_l, 1'b1);
    for (int i = 0; i < 12; i++) @(negedge clk);

    // MSB first.
    send(1, 8'h80, 9'b100000001);
    wait_idle();
    send(1, 8'h03, 9'b000000110);
    wait_idle();

`ifdef PARITY_ERR_INJ_EN
    err_inj_l = 1'b1;
    send(0, 8'hA5, 9'b101001011);
    err_inj_l = 1'b0;
    wait_idle();
    send(0, 8'hA5, 9'b101001010);
    wait_idle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
